// File: rtl/nios_lcd_pkg.sv
// Shared constants and state encoding for the LCD pixel reader.
//   ADDR_W_DEF / DATA_W_DEF         : default memory word-address and data widths
//   FIFO_DEPTH_DEF / READ_LATENCY_DEF : default output buffer depth and slave read latency
//   state_t                         : reader FSM states ST_IDLE..ST_ABORT
package nios_lcd_pkg;

  localparam int ADDR_W_DEF       = 14;
  localparam int DATA_W_DEF       = 32;
  localparam int FIFO_DEPTH_DEF   = 16;
  localparam int READ_LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

endpackage

// File: rtl/nios_lcd_pixel_fifo.sv
// Show-ahead FIFO buffering returned read data ahead of the pixel stream.
// The head word is presented on o_data whenever o_empty is low; i_pop consumes it.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write one word (ignored when full)
//   i_pop          : consume the head word (ignored when empty)
//   i_flush        : discard all contents; wins over push/pop
//   o_data         : head word
//   o_used         : number of stored words
//   o_empty/o_full : occupancy flags
module nios_lcd_pixel_fifo
  import nios_lcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [DATA_W-1:0]      o_data,
  output logic [$clog2(DEPTH):0] o_used,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_used;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_used == '0);
  assign o_full    = (r_used == CNT_W'(DEPTH));
  assign o_used    = r_used;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_do_push && !w_do_pop)      r_used <= r_used + CNT_ONE;
      else if (!w_do_push && w_do_pop) r_used <= r_used - CNT_ONE;
    end
  end

  // Storage is not reset; nothing reads it before it has been written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/nios_lcd_pixel_reader.sv
// Avalon-MM read master streaming a buffer from on-chip memory to the LCD pixel pipeline.
// The CPU programs ctl_base/ctl_count, pulses ctl_start and polls ctl_busy/ctl_done.
//   ctl_*   : control (start/abort pulses, base, count, busy, done)
//   avm_*   : Avalon-MM read master (fixed read latency, no readdatavalid)
//   pix_*   : valid/ready pixel stream with pix_last on the final word
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; zero-count start only pulses done
// ST_FETCH | issuing reads, throttled by buffer space
// ST_DRAIN | all reads issued; streaming out the remaining words
// ST_ABORT | waiting for in-flight reads to return, discarding them
module nios_lcd_pixel_reader
  import nios_lcd_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ctl_start,
  input  logic              ctl_abort,
  input  logic [ADDR_W-1:0] ctl_base,
  input  logic [ADDR_W:0]   ctl_count,
  output logic              ctl_busy,
  output logic              ctl_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              pix_last,
  input  logic              pix_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int WRD_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [WRD_W-1:0]  WORD_ONE = WRD_W'(1);
  localparam logic [CNT_W-1:0]  FLY_ONE  = CNT_W'(1);
  localparam logic [SUM_W-1:0]  DEPTH_V  = SUM_W'(FIFO_DEPTH);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [WRD_W-1:0]        r_count;
  logic [WRD_W-1:0]        r_issued;
  logic [WRD_W-1:0]        r_popped;
  logic [CNT_W-1:0]        r_inflight;
  logic [READ_LATENCY-1:0] r_lat;
  logic                    r_zero_done;

  logic              w_idle_start;
  logic              w_start_ok;
  logic              w_zero_start;
  logic              w_accept;
  logic              w_ret;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_final;
  logic              w_room;
  logic [SUM_W-1:0]  w_occupancy;
  logic [DATA_W-1:0] w_fifo_data;
  logic [CNT_W-1:0]  w_fifo_used;
  logic              w_fifo_empty;
  logic              w_fifo_full;

  // Buffered plus in-flight words never exceed the FIFO depth, so a return always has a slot.
  assign w_occupancy = {1'b0, w_fifo_used} + {1'b0, r_inflight};
  assign w_room      = (w_occupancy < DEPTH_V);

  // Request depends only on registered state; it cannot drop during a stall because
  // occupancy only grows on an accept.
  assign avm_read    = (r_state == ST_FETCH) && w_room && (r_issued < r_count);
  assign avm_address = r_addr;
  assign w_accept    = avm_read & ~avm_waitrequest;
  assign w_ret       = r_lat[READ_LATENCY-1];

  assign w_push    = w_ret & (r_state != ST_ABORT);
  assign w_flush   = (r_state == ST_ABORT);
  assign pix_valid = ~w_fifo_empty & (r_state != ST_ABORT);
  assign pix_data  = pix_valid ? w_fifo_data : '0;
  assign pix_last  = pix_valid & (r_popped == r_count - WORD_ONE);
  assign w_pop     = pix_valid & pix_ready;

  // Abort wins over a simultaneous start.
  assign w_idle_start = (r_state == ST_IDLE) && ctl_start && !ctl_abort;
  assign w_start_ok   = w_idle_start && (ctl_count != '0);
  assign w_zero_start = w_idle_start && (ctl_count == '0);

  assign ctl_busy = (r_state != ST_IDLE);
  assign ctl_done = r_zero_done | w_final;

  always_comb begin
    w_state_nxt = r_state;
    w_final     = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (ctl_abort) w_state_nxt = ST_ABORT;
        else if (w_accept && (r_issued + WORD_ONE == r_count)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ctl_abort) w_state_nxt = ST_ABORT;
        else if (w_pop && pix_last) begin
          w_state_nxt = ST_IDLE;
          w_final     = 1'b1;
        end
      end
      ST_ABORT: if (r_inflight == '0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_zero_done <= w_zero_start;
      if (w_start_ok) begin
        r_addr   <= ctl_base;
        r_count  <= ctl_count;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_accept) begin
          r_addr   <= r_addr + ADDR_ONE;
          r_issued <= r_issued + WORD_ONE;
        end
        if (w_pop) r_popped <= r_popped + WORD_ONE;
      end
    end
  end

  // Accept flags ride this shift register so the return cycle is known without readdatavalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat      <= '0;
      r_inflight <= '0;
    end else begin
      r_lat[0] <= w_accept;
      for (int i = 1; i < READ_LATENCY; i++) r_lat[i] <= r_lat[i-1];
      if (w_accept && !w_ret)      r_inflight <= r_inflight + FLY_ONE;
      else if (!w_accept && w_ret) r_inflight <= r_inflight - FLY_ONE;
    end
  end

  nios_lcd_pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (avm_readdata),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fifo_data),
    .o_used  (w_fifo_used),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(w_push && w_fifo_full));

endmodule
